// File: rtl/msk_elastic_fifo.sv
// msk_elastic_fifo: masked, share-preserving FIFO with valid/ready on both sides.
// Each entry holds an opaque bundle of count*d shares. Shares are stored and
// forwarded bit-for-bit and are never combined. All control (pointers, level,
// enables) is public and never depends on masked data.
module msk_elastic_fifo #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [count*d-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [count*d-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int W  = count * d;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_we;
  logic [PW-1:0]    w_wrPtrNext;
  logic [PW-1:0]    w_rdPtrNext;

  // Handshake flags depend only on registered occupancy and reset, never on
  // in_valid/out_ready, so no combinational path crosses the FIFO.
  always_comb begin
    w_full    = (r_level == FULL_LEVEL);
    in_ready  = !w_full && !rst;
    out_valid = (r_level != '0);
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
  end

  // Pointer increments wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
    w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
  end

  // Per-entry write enables decoded from the public write pointer.
  always_comb begin
    w_we = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_we[k] = w_push && (r_wrPtr == PW'(k));
    end
  end

  // Storage entries use mux-feedback enables (hold when not selected); no
  // clock gating and no reset, since contents are don't-care while invalid.
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_we[k]) begin
        r_mem[k] <= in_data;
      end else begin
        r_mem[k] <= r_mem[k];
      end
    end
  end

  // Pointers and occupancy; reset discards all stored words at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Read path is a plain register mux whose select only moves on clock edges.
  assign out_data = r_mem[r_rdPtr];
  assign level    = r_level;

  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_level <= FULL_LEVEL);
      assert (!(w_pop && !w_push && (r_level == '0)));
      assert (!(w_push && !w_pop && (r_level == FULL_LEVEL)));
    end
  end

endmodule

// File: tb/tb_msk_elastic_fifo.sv
// Bench for msk_elastic_fifo: two instances (d=2/count=8/DEPTH=4 and
// d=3/count=4/DEPTH=3) with a queue scoreboard per instance.
module tb_msk_elastic_fifo;

  localparam int NA = 4;
  localparam int WA = 16;
  localparam int DB = 3;
  localparam int CB = 4;
  localparam int NB = 3;
  localparam int WB = 12;

  typedef struct {
    logic [WB-1:0] bundle;
    logic [CB-1:0] plain;
  } itemB_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstA, inValidA, outReadyA, inReadyA, outValidA;
  logic [WA-1:0] inDataA, outDataA;
  logic [2:0]    levelA;

  logic          rstB, inValidB, outReadyB, inReadyB, outValidB;
  logic [WB-1:0] inDataB, outDataB;
  logic [CB-1:0] inPlainB;
  logic [1:0]    levelB;

  int checks = 0;
  int errors = 0;

  logic [WA-1:0] qA[$];
  itemB_t        qB[$];
  int            mLevelA = 0;
  int            mLevelB = 0;
  logic          pushA = 1'b0, popA = 1'b0, pushB = 1'b0, popB = 1'b0;
  logic          lastAcceptB = 1'b0;

  msk_elastic_fifo #(.d(2), .count(8), .DEPTH(NA)) dutA (
    .clk(clk), .rst(rstA), .in_valid(inValidA), .in_ready(inReadyA),
    .in_data(inDataA), .out_valid(outValidA), .out_ready(outReadyA),
    .out_data(outDataA), .level(levelA)
  );

  msk_elastic_fifo #(.d(DB), .count(CB), .DEPTH(NB)) dutB (
    .clk(clk), .rst(rstB), .in_valid(inValidB), .in_ready(inReadyB),
    .in_data(inDataB), .out_valid(outValidB), .out_ready(outReadyB),
    .out_data(outDataB), .level(levelB)
  );

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives instance A for one cycle, returning at posedge+2 of the next cycle.
  task automatic applyStimulus(input logic v, input logic [WA-1:0] dat, input logic r);
    inValidA  = v;
    inDataA   = dat;
    outReadyA = r;
    @(posedge clk);
    #2;
  endtask

  // Builds a random masked word for instance B: d-1 random shares per bit,
  // last share chosen so the XOR of all shares equals the plain bit.
  task automatic makeWordB(output logic [WB-1:0] bundle, output logic [CB-1:0] plain);
    logic s0, s1;
    plain = CB'($urandom_range(0, (1 << CB) - 1));
    for (int i = 0; i < CB; i++) begin
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      bundle[i*DB + 0] = s0;
      bundle[i*DB + 1] = s1;
      bundle[i*DB + 2] = plain[i] ^ s0 ^ s1;
    end
  endtask

  // Scoreboard writers: record every word the model says is accepted.
  always @(negedge clk) begin
    pushA = !rstA && (mLevelA != NA) && inValidA;
    if (pushA) qA.push_back(inDataA);
    pushB = !rstB && (mLevelB != NB) && inValidB;
    if (pushB) qB.push_back('{bundle: inDataB, plain: inPlainB});
    lastAcceptB = pushB;
  end

  // Monitor for A: flags against the occupancy model, popped words against the queue.
  always @(negedge clk) begin
    logic [WA-1:0] expWord;
    checkOutput("A in_ready", 32'(inReadyA), 32'(!rstA && (mLevelA != NA)));
    checkOutput("A out_valid", 32'(outValidA), 32'(mLevelA != 0));
    checkOutput("A level", 32'(levelA), 32'(mLevelA));
    popA = !rstA && (mLevelA != 0) && outReadyA;
    if (popA) begin
      if (qA.size() == 0) begin
        checkOutput("A queue underrun", 32'(qA.size()), 32'd1);
      end else begin
        expWord = qA.pop_front();
        checkOutput("A out_data", 32'(outDataA), 32'(expWord));
      end
    end
  end

  // Monitor for B: share-for-share bundle compare plus unmasked XOR cross-check.
  always @(negedge clk) begin
    itemB_t        it;
    logic [CB-1:0] recomb;
    checkOutput("B in_ready", 32'(inReadyB), 32'(!rstB && (mLevelB != NB)));
    checkOutput("B out_valid", 32'(outValidB), 32'(mLevelB != 0));
    checkOutput("B level", 32'(levelB), 32'(mLevelB));
    popB = !rstB && (mLevelB != 0) && outReadyB;
    if (popB) begin
      if (qB.size() == 0) begin
        checkOutput("B queue underrun", 32'(qB.size()), 32'd1);
      end else begin
        it = qB.pop_front();
        checkOutput("B out_data", 32'(outDataB), 32'(it.bundle));
        for (int i = 0; i < CB; i++) recomb[i] = ^outDataB[i*DB +: DB];
        checkOutput("B unmasked", 32'(recomb), 32'(it.plain));
      end
    end
  end

  // Occupancy models advance on the clock edge; reset empties the scoreboard.
  always @(posedge clk) begin
    if (rstA) begin
      mLevelA = 0;
      qA.delete();
    end else begin
      mLevelA = mLevelA + int'(pushA) - int'(popA);
    end
    if (rstB) begin
      mLevelB = 0;
      qB.delete();
    end else begin
      mLevelB = mLevelB + int'(pushB) - int'(popB);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WB-1:0] b;
    logic [CB-1:0] p;
    int            waitCycles;

    rstA = 1'b1; inValidA = 1'b0; inDataA = '0; outReadyA = 1'b0;
    rstB = 1'b1; inValidB = 1'b0; inDataB = '0; inPlainB = '0; outReadyB = 1'b0;

    // Reset behaviour of A.
    @(posedge clk); #2;
    checkOutput("A in_ready during rst", 32'(inReadyA), 32'd0);
    @(posedge clk); #2;
    rstA = 1'b0;
    #1;
    checkOutput("A in_ready after rst", 32'(inReadyA), 32'd1);
    checkOutput("A level after rst", 32'(levelA), 32'd0);
    checkOutput("A out_valid after rst", 32'(outValidA), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    // Fill to full with the consumer stalled.
    applyStimulus(1'b1, 16'h1234, 1'b0);
    checkOutput("A first push visible", 32'(outValidA), 32'd1);
    checkOutput("A head word", 32'(outDataA), 32'h1234);
    applyStimulus(1'b1, 16'hABCD, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    checkOutput("A level full", 32'(levelA), 32'd4);
    checkOutput("A in_ready full", 32'(inReadyA), 32'd0);

    // Fifth push is refused while full.
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("A level after refused push", 32'(levelA), 32'd4);

    // Full with both sides active: pop only, then the held push lands.
    applyStimulus(1'b1, 16'h5555, 1'b1);
    checkOutput("A level 4->3", 32'(levelA), 32'd3);
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("A level 3->4", 32'(levelA), 32'd4);

    // Drain everything.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("A level drained", 32'(levelA), 32'd0);
    checkOutput("A out_valid drained", 32'(outValidA), 32'd0);

    // Reset mid-stream with two words stored.
    applyStimulus(1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0);
    checkOutput("A level before mid rst", 32'(levelA), 32'd2);
    rstA = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    rstA = 1'b0;
    checkOutput("A level after mid rst", 32'(levelA), 32'd0);
    checkOutput("A out_valid after mid rst", 32'(outValidA), 32'd0);

    // Simultaneous push and pop at level 1.
    applyStimulus(1'b1, 16'h3333, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b1);
    checkOutput("A level push+pop", 32'(levelA), 32'd1);
    checkOutput("A new head after push+pop", 32'(outDataA), 32'h4444);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("A scoreboard empty", 32'(qA.size()), 32'd0);

    // Instance B: reset release.
    rstB = 1'b0;
    @(posedge clk); #2;

    // Continuous push and pop every cycle through a depth-3 FIFO.
    for (int i = 0; i < 100; i++) begin
      makeWordB(b, p);
      inValidB = 1'b1; inDataB = b; inPlainB = p; outReadyB = 1'b1;
      @(posedge clk); #2;
      checkOutput("B level streaming", 32'(levelB), 32'd1);
    end
    inValidB = 1'b0;
    @(posedge clk); #2;
    checkOutput("B level after stream", 32'(levelB), 32'd0);

    // Random valid/ready on both sides; the producer holds a refused word.
    for (int i = 0; i < 300; i++) begin
      if (!(inValidB && !lastAcceptB)) begin
        if ($urandom_range(0, 99) < 60) begin
          makeWordB(b, p);
          inValidB = 1'b1; inDataB = b; inPlainB = p;
        end else begin
          inValidB = 1'b0;
        end
      end
      outReadyB = ($urandom_range(0, 99) < 55);
      @(posedge clk); #2;
    end

    // Drain with a bounded wait.
    inValidB = 1'b0;
    outReadyB = 1'b1;
    waitCycles = 0;
    while (qB.size() != 0 && waitCycles < 20) begin
      @(posedge clk); #2;
      waitCycles++;
    end
    outReadyB = 1'b0;
    checkOutput("B scoreboard drained", 32'(qB.size()), 32'd0);
    checkOutput("B level final", 32'(levelB), 32'd0);

    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
